// File: rtl/register_bank_sync_pkg.sv
// Shared types and helpers for register_bank_sync: register type codes,
// mask-to-type mapping and byte-lane merge.
package register_bank_sync_pkg;

  typedef enum logic [1:0] {
    REG_RW     = 2'd0,
    REG_RO     = 2'd1,
    REG_W1C    = 2'd2,
    REG_SHADOW = 2'd3
  } reg_type_e;

  // Helpers work on fixed maximum widths; callers size-cast in and out.
  localparam int MAX_REGS = 256;
  localparam int MAX_DW   = 256;
  localparam int MAX_BE   = MAX_DW / 8;
  localparam int IDX_W    = $clog2(MAX_REGS);

  // Overlapping masks resolve as RO > W1C > SHADOW > RW.
  function automatic reg_type_e reg_type(input logic [IDX_W-1:0]    idx,
                                         input logic [MAX_REGS-1:0] ro,
                                         input logic [MAX_REGS-1:0] w1c,
                                         input logic [MAX_REGS-1:0] shadow);
    reg_type_e t;
    t = REG_RW;
    if (ro[idx])          t = REG_RO;
    else if (w1c[idx])    t = REG_W1C;
    else if (shadow[idx]) t = REG_SHADOW;
    return t;
  endfunction

  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_v,
                                                   input logic [MAX_DW-1:0] new_v,
                                                   input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] res;
    for (int k = 0; k < MAX_BE; k++)
      res[k*8 +: 8] = be[k] ? new_v[k*8 +: 8] : old_v[k*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/register_bank_sync_cell.sv
// One register of the bank; TYPE selects RW, RO, W1C or double-buffered SHADOW.
module register_bank_cell
  import register_bank_sync_pkg::*;
#(
  parameter reg_type_e             TYPE        = REG_RW,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   set,
  input  logic                    commit,
  input  logic [DATA_WIDTH-1:0]   live,
  output logic [DATA_WIDTH-1:0]   value,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] merged_q;
  logic [DATA_WIDTH-1:0] merged_sh;
  logic [DATA_WIDTH-1:0] clr;

  assign merged_q  = DATA_WIDTH'(byte_merge(MAX_DW'(q), MAX_DW'(wdata), MAX_BE'(be)));
  assign merged_sh = DATA_WIDTH'(byte_merge(MAX_DW'(sh), MAX_DW'(wdata), MAX_BE'(be)));
  // Merging onto zero leaves exactly the written ones in enabled lanes.
  assign clr = wr ? DATA_WIDTH'(byte_merge('0, MAX_DW'(wdata), MAX_BE'(be))) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q  <= RESET_VALUE;
      sh <= RESET_VALUE;
    end else begin
      case (TYPE)
        REG_RW:  if (wr) q <= merged_q;
        REG_W1C: q <= (q & ~clr) | set;
        REG_SHADOW: begin
          if (wr) sh <= merged_sh;
          // A write landing on the commit edge goes straight through to active.
          if (commit) q <= wr ? merged_sh : sh;
        end
        default: ;
      endcase
    end
  end

  assign value = (TYPE == REG_RO) ? live : q;
  assign rdata = (TYPE == REG_RO) ? live : (TYPE == REG_SHADOW) ? sh : q;

  logic unused_ok;
  assign unused_ok = ^{set, live, commit, wr, be, wdata, sh, merged_q, merged_sh, clr};

endmodule

// File: rtl/register_bank_sync.sv
// Synchronous parametrised register bank: address decode, registered read
// mux, one-cycle ack and per-register write strobes around NUM_REGS cells.
module register_bank_sync
  import register_bank_sync_pkg::*;
#(
  parameter int                               ADDR_WIDTH   = 4,
  parameter int                               DATA_WIDTH   = 16,
  parameter int                               NUM_REGS     = 16,
  parameter logic [NUM_REGS-1:0]              RO_MASK      = '1,
  parameter logic [NUM_REGS-1:0]              W1C_MASK     = '0,
  parameter logic [NUM_REGS-1:0]              SHADOW_MASK  = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALUES = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           bus_en,
  input  logic                           bus_rd,
  input  logic                           bus_wr,
  input  logic [DATA_WIDTH/8-1:0]        bus_be,
  input  logic [ADDR_WIDTH-1:0]          bus_addr,
  input  logic [DATA_WIDTH-1:0]          bus_data_in,
  output logic [DATA_WIDTH-1:0]          bus_data_out,
  output logic                           bus_ack,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] values_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] set_in,
  input  logic                           commit,
  output logic [NUM_REGS*DATA_WIDTH-1:0] values_out,
  output logic [NUM_REGS-1:0]            write_strobe
);

  localparam logic [MAX_REGS-1:0] RO_EXT  = MAX_REGS'(RO_MASK);
  localparam logic [MAX_REGS-1:0] W1C_EXT = MAX_REGS'(W1C_MASK);
  localparam logic [MAX_REGS-1:0] SH_EXT  = MAX_REGS'(SHADOW_MASK);

  // Handshake: an access is taken at a rising edge when bus_en is high and
  // exactly one of bus_rd/bus_wr is high; bus_ack is high for the single
  // following cycle and bus_data_out is valid while bus_ack is high.
  logic                  acc;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [NUM_REGS-1:0]   cell_wr;
  logic [DATA_WIDTH-1:0] cell_rdata [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_mux;

  assign acc    = bus_en & (bus_rd ^ bus_wr);
  assign wr_acc = acc & bus_wr;
  assign rd_acc = acc & bus_rd;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam reg_type_e T = reg_type(IDX_W'(i), RO_EXT, W1C_EXT, SH_EXT);

    // Out-of-range addresses match no cell, so they neither write nor strobe.
    assign cell_wr[i] = wr_acc & (bus_addr == ADDR_WIDTH'(i));

    register_bank_cell #(
      .TYPE        (T),
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .wr     (cell_wr[i]),
      .be     (bus_be),
      .wdata  (bus_data_in),
      .set    (set_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .commit (commit),
      .live   (values_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .value  (values_out[i*DATA_WIDTH +: DATA_WIDTH]),
      .rdata  (cell_rdata[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus_addr == ADDR_WIDTH'(i)) rd_mux = cell_rdata[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_ack      <= 1'b0;
      bus_data_out <= '0;
      write_strobe <= '0;
    end else begin
      bus_ack      <= acc;
      write_strobe <= cell_wr;
      if (rd_acc) bus_data_out <= rd_mux;
    end
  end

endmodule

// File: tb/tb_register_bank_sync.sv
// Self-checking bench for register_bank_sync: vector table plus hand-written
// W1C, shadow, RO, illegal-access and asynchronous-reset sequences.
module tb_register_bank_sync;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam logic [NR*DW-1:0] RV = 128'h0000_0000_0000_0000_0000_A5A5_0000_0000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             bus_en = 1'b0;
  logic             bus_rd = 1'b0;
  logic             bus_wr = 1'b0;
  logic [DW/8-1:0]  bus_be = '0;
  logic [AW-1:0]    bus_addr = '0;
  logic [DW-1:0]    bus_data_in = '0;
  logic [DW-1:0]    bus_data_out;
  logic             bus_ack;
  logic [NR*DW-1:0] values_in = '0;
  logic [NR*DW-1:0] set_in = '0;
  logic             commit = 1'b0;
  logic [NR*DW-1:0] values_out;
  logic [NR-1:0]    write_strobe;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd = '0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [1:0]    be;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[11];

  register_bank_sync #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_REGS     (NR),
    .RO_MASK      (8'h01),
    .W1C_MASK     (8'h08),
    .SHADOW_MASK  (8'h10),
    .RESET_VALUES (RV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus_en       (bus_en),
    .bus_rd       (bus_rd),
    .bus_wr       (bus_wr),
    .bus_be       (bus_be),
    .bus_addr     (bus_addr),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out),
    .bus_ack      (bus_ack),
    .values_in    (values_in),
    .set_in       (set_in),
    .commit       (commit),
    .values_out   (values_out),
    .write_strobe (write_strobe)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] vo(input int r);
    return values_out[r*DW +: DW];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Driver: one access, expected read data goes through the scoreboard queue.
  task automatic access(input logic wr, input logic [AW-1:0] addr, input logic [1:0] be,
                        input logic [DW-1:0] data, input logic [DW-1:0] exp,
                        input logic [NR*DW-1:0] sv, input logic com);
    logic [NR-1:0] exp_strobe;
    @(negedge clk);
    chk("ack_idle", 32'(bus_ack), 32'd0);
    bus_en = 1'b1; bus_wr = wr; bus_rd = !wr; bus_addr = addr; bus_be = be;
    bus_data_in = data; set_in = sv; commit = com;
    if (!wr) exp_q.push_back(exp);
    exp_strobe = (wr && addr < AW'(NR)) ? (NR'(1) << addr) : '0;
    @(negedge clk);
    bus_en = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0; set_in = '0; commit = 1'b0;
    chk("ack", 32'(bus_ack), 32'd1);
    chk("strobe", 32'(write_strobe), 32'(exp_strobe));
    if (!wr) begin
      if (exp_q.size() == 0) chk("queue_underflow", 32'd0, 32'd1);
      else last_rd = exp_q.pop_front();
      chk("rdata", 32'(bus_data_out), 32'(last_rd));
    end else begin
      chk("rdata_hold", 32'(bus_data_out), 32'(last_rd));
    end
  endtask

  initial begin
    logic [NR*DW-1:0] sv;

    for (int r = 0; r < NR; r++) values_in[r*DW +: DW] = DW'($urandom_range(0, 65535));
    values_in[0 +: DW] = 16'hC0DE;

    vecs[0]  = '{1'b0, 4'd2,  2'b11, 16'h0000, 16'hA5A5};
    vecs[1]  = '{1'b1, 4'd1,  2'b11, 16'h1234, 16'h0000};
    vecs[2]  = '{1'b1, 4'd1,  2'b01, 16'hFFFF, 16'h0000};
    vecs[3]  = '{1'b0, 4'd1,  2'b11, 16'h0000, 16'h12FF};
    vecs[4]  = '{1'b1, 4'd0,  2'b11, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 4'd0,  2'b11, 16'h0000, 16'hC0DE};
    vecs[6]  = '{1'b0, 4'd15, 2'b11, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, 4'd15, 2'b11, 16'h5555, 16'h0000};
    vecs[8]  = '{1'b1, 4'd5,  2'b10, 16'hABCD, 16'h0000};
    vecs[9]  = '{1'b0, 4'd5,  2'b11, 16'h0000, 16'hAB00};
    vecs[10] = '{1'b0, 4'd6,  2'b11, 16'h0000, 16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_reg2", 32'(vo(2)), 32'h0000A5A5);
    chk("rst_reg1", 32'(vo(1)), 32'h0);
    chk("rst_ack", 32'(bus_ack), 32'd0);
    chk("rst_dout", 32'(bus_data_out), 32'h0);
    chk("rst_strobe", 32'(write_strobe), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++)
      access(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].data, vecs[i].exp, '0, 1'b0);
    chk("reg1_val", 32'(vo(1)), 32'h000012FF);
    chk("reg5_val", 32'(vo(5)), 32'h0000AB00);

    // RO passthrough is combinational
    chk("ro_pass", 32'(vo(0)), 32'h0000C0DE);
    @(negedge clk);
    values_in[0 +: DW] = 16'h1111;
    #1 chk("ro_pass_live", 32'(vo(0)), 32'h00001111);
    access(1'b0, 4'd0, 2'b11, 16'h0, 16'h1111, '0, 1'b0);

    // W1C: set bits 0 and 4, clear bit 0
    @(negedge clk);
    set_in[3*DW + 0] = 1'b1;
    set_in[3*DW + 4] = 1'b1;
    @(negedge clk);
    set_in = '0;
    chk("w1c_set", 32'(vo(3)), 32'h00000011);
    access(1'b1, 4'd3, 2'b11, 16'h0001, 16'h0, '0, 1'b0);
    access(1'b0, 4'd3, 2'b11, 16'h0000, 16'h0010, '0, 1'b0);
    sv = '0;
    sv[3*DW + 0] = 1'b1;
    access(1'b1, 4'd3, 2'b11, 16'h0001, 16'h0, sv, 1'b0);
    access(1'b0, 4'd3, 2'b11, 16'h0000, 16'h0011, '0, 1'b0);

    // SHADOW: pending write, commit, write coinciding with commit
    access(1'b1, 4'd4, 2'b11, 16'h0040, 16'h0, '0, 1'b0);
    access(1'b0, 4'd4, 2'b11, 16'h0000, 16'h0040, '0, 1'b0);
    chk("shadow_pending", 32'(vo(4)), 32'h0);
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk("shadow_commit", 32'(vo(4)), 32'h00000040);
    access(1'b1, 4'd4, 2'b11, 16'h0080, 16'h0, '0, 1'b1);
    chk("shadow_coincide", 32'(vo(4)), 32'h00000080);

    // Illegal rd+wr: no ack, no change
    @(negedge clk);
    bus_en = 1'b1; bus_rd = 1'b1; bus_wr = 1'b1; bus_addr = 4'd1; bus_be = 2'b11;
    bus_data_in = 16'h0000;
    @(negedge clk);
    bus_en = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0;
    chk("illegal_ack", 32'(bus_ack), 32'd0);
    chk("illegal_strobe", 32'(write_strobe), 32'h0);
    chk("illegal_reg1", 32'(vo(1)), 32'h000012FF);
    chk("illegal_dout", 32'(bus_data_out), 32'(last_rd));

    // Reset pulled low while a write is presented, before its edge
    @(negedge clk);
    bus_en = 1'b1; bus_wr = 1'b1; bus_addr = 4'd1; bus_be = 2'b11; bus_data_in = 16'h7777;
    #2 reset = 1'b0;
    @(negedge clk);
    bus_en = 1'b0; bus_wr = 1'b0;
    chk("arst_ack", 32'(bus_ack), 32'd0);
    chk("arst_strobe", 32'(write_strobe), 32'h0);
    chk("arst_reg1", 32'(vo(1)), 32'h0);
    chk("arst_reg4", 32'(vo(4)), 32'h0);
    chk("arst_reg3", 32'(vo(3)), 32'h0);
    chk("arst_dout", 32'(bus_data_out), 32'h0);
    #2 reset = 1'b1;
    last_rd = '0;
    @(negedge clk);
    chk("arst_ack_after", 32'(bus_ack), 32'd0);
    chk("arst_reg1_after", 32'(vo(1)), 32'h0);
    access(1'b0, 4'd2, 2'b11, 16'h0, 16'hA5A5, '0, 1'b0);
    access(1'b0, 4'd4, 2'b11, 16'h0, 16'h0000, '0, 1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank_sync.md
Name: register_bank_sync

Overview:
- Parametrised successor to the primary/tile control register files: a fully synchronous register bank on the system clock.
- Generalises data width, register count and byte lanes.
- Adds per-register types:
  - RW: read/write.
  - RO: read-only.
  - W1C: sticky status, write-1-to-clear.
  - SHADOW: double-buffered, committed on a frame/line pulse.
- Adds a registered read path with a one-cycle ack handshake, and per-register write strobes.
- Sits between the host memory bus decoder and the video/tile engines.

Parameters:
- ADDR_WIDTH, 4, register address bus width.
- DATA_WIDTH, 16, register and data bus width; must be a multiple of 8.
- NUM_REGS, 16, number of registers; must be <= 2^ADDR_WIDTH.
- RO_MASK, all ones, bit i = 1 makes register i read-only.
- W1C_MASK, 0, bit i = 1 makes register i sticky status (write-1-to-clear).
- SHADOW_MASK, 0, bit i = 1 makes register i double-buffered.
- RESET_VALUES, 0, flattened NUM_REGS*DATA_WIDTH reset image for storage registers.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- bus_en  in  1  access enable.
- bus_rd  in  1  read request.
- bus_wr  in  1  write request.
- bus_be  in  DATA_WIDTH/8  byte enables.
- bus_addr  in  ADDR_WIDTH  register address.
- bus_data_in  in  DATA_WIDTH  write data.
- bus_data_out  out  DATA_WIDTH  registered read data.
- bus_ack  out  1  one-cycle completion pulse.
- values_in  in  NUM_REGS*DATA_WIDTH  live values for RO registers.
- set_in  in  NUM_REGS*DATA_WIDTH  W1C set pulses, one bit per status bit.
- commit  in  1  shadow-to-active transfer pulse (e.g. vblank start).
- values_out  out  NUM_REGS*DATA_WIDTH  active register values.
- write_strobe  out  NUM_REGS  one-cycle pulse per register written.

Behaviour:
- Register type priority when masks overlap: RO > W1C > SHADOW > RW. A register with no mask bit set is RW.
- Reset (reset low, asynchronous):
  - Storage registers and shadow copies take RESET_VALUES.
  - bus_data_out = 0, bus_ack = 0, write_strobe = 0.
  - Reset asserted mid-access aborts the access; no ack is produced after release.
- Access acceptance:
  - Accepted at a rising edge when bus_en=1 and exactly one of bus_rd/bus_wr is 1.
  - bus_rd=bus_wr=1 is ignored: no ack, no state change.
  - Back-to-back accesses are allowed on every cycle; there is no busy state.
- Ack timing: bus_ack is high in the cycle after acceptance, for exactly one cycle per accepted access.
- Read:
  - bus_data_out is registered at the acceptance edge and valid while bus_ack=1.
  - It holds its value until the next accepted read.
  - RO returns the sampled values_in slice; W1C returns stored status.
  - SHADOW returns the shadow (pending) value; RW returns storage.
- Write:
  - Byte lane k is updated only if bus_be[k]=1.
  - RO: write is discarded, but ack and write_strobe still fire.
  - RW: storage <= merged data.
  - SHADOW: shadow <= merged data; the active copy is unchanged until commit.
  - W1C: each bit with data=1 in an enabled lane clears.
- W1C set/clear:
  - Any set_in bit = 1 sets the corresponding status bit at the next edge.
  - If set and clear coincide on a bit, set wins.
- write_strobe[i]: pulses in the ack cycle for an accepted write to register i, whatever its type.
- Out-of-range address (>= NUM_REGS): reads return 0, writes are dropped, no strobe, ack still fires.
- Commit:
  - At an edge with commit=1, every SHADOW register's active copy takes the shadow value.
  - If a write to a SHADOW register is accepted at the same edge, active takes the newly merged value, so no update is lost.
- values_out:
  - RW and W1C: storage.
  - SHADOW: active copy.
  - RO: values_in passthrough (combinational).

Decomposition:
- Shared package holds:
  - Type constants REG_RW, REG_RO, REG_W1C, REG_SHADOW.
  - A function mapping index plus masks to a type.
  - A byte-merge function: old, new, be -> merged.
- One sub-module, register_bank_cell: a single register parametrised by TYPE, DATA_WIDTH and RESET_VALUE. It contains storage, the shadow copy and the W1C logic, and is instantiated NUM_REGS times in a generate loop.
- The top level holds address decode, read mux, ack and strobe pipeline.

Test Plan:
- Reset check:
  - Stimulus: RESET_VALUES reg2=16'hA5A5; hold reset low, then release.
  - Response: values_out reg2=A5A5; bus_ack=0.
  - Then read reg2 -> bus_data_out=A5A5 with one ack pulse on the next cycle.
- RW byte enables: write reg1=16'h1234 with be=2'b11, then write 16'hFFFF with be=2'b01 -> reg1 reads 16'h12FF; write_strobe[1] pulses twice.
- W1C set/clear:
  - Reg3 is W1C; set_in bits 0 and 4 are pulsed, then the status is written with 16'h0001 -> reads 16'h0010.
  - Set bit 0 and clear bit 0 in the same cycle -> bit 0 remains 1.
- SHADOW commit:
  - Reg4 is SHADOW, reset value 0; write 16'h0040 -> read returns 0040, values_out reg4=0000.
  - Pulse commit -> values_out reg4=0040.
  - A write of 0080 coinciding with commit -> values_out=0080.
- RO and out-of-range:
  - Reg0 is RO, values_in=16'hC0DE; write 16'h0000 then read -> C0DE, with acks for both accesses.
  - Read address 15 with NUM_REGS=8 -> 0000, ack=1.
- Illegal and async reset:
  - bus_rd=bus_wr=1 -> no ack and no change.
  - A write accepted, then reset pulled low before the ack edge -> ack never asserts; reg returns to its reset value.
